// File: rtl/uart_rx_fifo_pkg.sv
// Shared encodings, FSM states and receive-queue entry layout for the UART receiver.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } rx_state_e;

  localparam int ENTRY_W    = 10;
  localparam int ENTRY_FERR = 9;
  localparam int ENTRY_PERR = 8;

  // Index of the final data bit for a data-bits code (5..8 bits -> 4..7).
  function automatic logic [2:0] last_bit_index(input logic [1:0] bits_code);
    return {1'b1, bits_code};
  endfunction

endpackage

// File: rtl/uart_rx_sync_fifo.sv
// First-word fall-through synchronous FIFO; the head word is visible on rdata
// whenever the queue is not empty, and reads as zero when it is.
module uart_rx_sync_fifo #(
  parameter  int WIDTH = 10,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign empty   = (count == '0);
  assign full    = count[AW];
  assign do_pop  = pop & ~empty;
  // A push into a full queue still lands when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // NOTE: storage is deliberately not reset; emptiness is carried by the
  // pointers alone and the head is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver: synchronised and filtered RX line, bit-centre sampling FSM,
// and an FWFT queue of {ferr, perr, data} entries with a sticky overrun flag.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int PERIOD_W   = 11,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [PERIOD_W-1:0]         i_period,
  input  logic                        i_rxd,
  input  logic [1:0]                  cfg_data_bits,
  input  logic [1:0]                  cfg_parity,
  input  logic                        cfg_stop2,
  input  logic                        rd_en,
  input  logic                        clr_overrun,
  output logic [7:0]                  o_data,
  output logic                        o_perr,
  output logic                        o_ferr,
  output logic                        o_valid,
  output logic [$clog2(FIFO_DEPTH):0] o_count,
  output logic                        o_overrun
);

  logic                rxd_s1, rxd_s2, line, line_d;
  logic [2:0]          hist;
  logic                line_edge, line_fall;
  rx_state_e           state, next_state;
  logic [PERIOD_W-1:0] cnt;
  logic                tick, frame_done, wr;
  logic [1:0]          lat_bits, lat_par;
  logic                lat_stop2, par_en;
  logic [2:0]          bit_idx;
  logic [7:0]          shreg;
  logic                perr, ferr;
  logic [ENTRY_W-1:0]  wr_entry, head;
  logic                fifo_full, fifo_empty;

  // Line idles high, so the filter starts high to avoid a phantom start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxd_s1 <= 1'b1;
      rxd_s2 <= 1'b1;
      hist   <= '1;
      line   <= 1'b1;
      line_d <= 1'b1;
    end else begin
      rxd_s1 <= i_rxd;
      rxd_s2 <= rxd_s1;
      hist   <= {hist[1:0], rxd_s2};
      if (&{hist, rxd_s2})       line <= 1'b1;
      else if (~|{hist, rxd_s2}) line <= 1'b0;
      line_d <= line;
    end
  end

  assign line_edge = line ^ line_d;
  assign line_fall = line_d & ~line;

  // Clearing on every filtered edge re-centres the sample point on each data transition.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                              cnt <= '0;
    else if (state == IDLE || line_edge || cnt == i_period) cnt <= '0;
    else                                                    cnt <= cnt + 1'b1;
  end

  assign tick   = (state != IDLE) && (cnt == (i_period >> 1));
  assign par_en = (lat_par == PAR_EVEN) || (lat_par == PAR_ODD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // NOTE: next_state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (line_fall) next_state = START;
      START:   if (tick) next_state = line ? IDLE : DATA;
      DATA:    if (tick && bit_idx == last_bit_index(lat_bits))
                 next_state = par_en ? PARITY : STOP1;
      PARITY:  if (tick) next_state = STOP1;
      STOP1:   if (tick) next_state = lat_stop2 ? STOP2 : IDLE;
      STOP2:   if (tick) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    frame_done = 1'b0;
    unique case (state)
      STOP1:   frame_done = tick && !lat_stop2;
      STOP2:   frame_done = tick;
      default: frame_done = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr        <= 1'b0;
      lat_bits  <= '0;
      lat_par   <= PAR_NONE;
      lat_stop2 <= 1'b0;
      bit_idx   <= '0;
      shreg     <= '0;
      perr      <= 1'b0;
      ferr      <= 1'b0;
    end else begin
      wr <= frame_done;
      if (state == IDLE && line_fall) begin
        lat_bits  <= cfg_data_bits;
        lat_par   <= cfg_parity;
        lat_stop2 <= cfg_stop2;
        bit_idx   <= '0;
        shreg     <= '0;
        perr      <= 1'b0;
        ferr      <= 1'b0;
      end
      if (tick) begin
        unique case (state)
          DATA: begin
            shreg[bit_idx] <= line;
            bit_idx        <= bit_idx + 1'b1;
          end
          PARITY:  perr <= line ^ ((lat_par == PAR_ODD) ? ~(^shreg) : (^shreg));
          STOP1:   ferr <= ~line;
          STOP2:   ferr <= ferr | ~line;
          default: ;
        endcase
      end
    end
  end

  assign wr_entry = {ferr, perr, shreg};

  uart_rx_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr),
    .wdata (wr_entry),
    .pop   (rd_en),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (o_count)
  );

  // A set in the same cycle as a clear wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          o_overrun <= 1'b0;
    else if (wr && fifo_full && !rd_en) o_overrun <= 1'b1;
    else if (clr_overrun)               o_overrun <= 1'b0;
  end

  assign o_data  = head[7:0];
  assign o_perr  = head[ENTRY_PERR];
  assign o_ferr  = head[ENTRY_FERR];
  assign o_valid = ~fifo_empty;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed frames plus randomized traffic
// checked against a queue-based model of the receive FIFO.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int PERIOD_W = 11;
  localparam int DEPTH    = 4;
  localparam int CW       = $clog2(DEPTH) + 1;

  logic                clk           = 1'b0;
  logic                reset         = 1'b1;
  logic [PERIOD_W-1:0] i_period      = 11'd103;
  logic                i_rxd         = 1'b1;
  logic [1:0]          cfg_data_bits = 2'd3;
  logic [1:0]          cfg_parity    = PAR_NONE;
  logic                cfg_stop2     = 1'b0;
  logic                rd_en         = 1'b0;
  logic                clr_overrun   = 1'b0;
  logic [7:0]          o_data;
  logic                o_perr, o_ferr, o_valid, o_overrun;
  logic [CW-1:0]       o_count;

  int         n_checks  = 0;
  int         n_fail    = 0;
  int         period    = 103;
  logic [9:0] model_q[$];
  logic       model_ovr = 1'b0;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .PERIOD_W   (PERIOD_W),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .i_period      (i_period),
    .i_rxd         (i_rxd),
    .cfg_data_bits (cfg_data_bits),
    .cfg_parity    (cfg_parity),
    .cfg_stop2     (cfg_stop2),
    .rd_en         (rd_en),
    .clr_overrun   (clr_overrun),
    .o_data        (o_data),
    .o_perr        (o_perr),
    .o_ferr        (o_ferr),
    .o_valid       (o_valid),
    .o_count       (o_count),
    .o_overrun     (o_overrun)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_period(input int p);
    period   = p;
    i_period = PERIOD_W'(p);
  endtask

  task automatic drive_bit(input logic b);
    i_rxd = b;
    repeat (period + 1) @(negedge clk);
  endtask

  task automatic model_push(input logic [9:0] e);
    if (model_q.size() < DEPTH) model_q.push_back(e);
    else                        model_ovr = 1'b1;
  endtask

  // One frame, starting at a falling clock edge; each bit lasts period+1 cycles.
  // With pop_on_push the head is popped exactly in the cycle the frame is written.
  task automatic send(input logic [7:0] data, input int nbits, input logic [1:0] par,
                      input logic stop2, input logic bad_par, input logic s1,
                      input logic s2, input logic scramble, input logic pop_on_push);
    logic [7:0] d;
    logic [9:0] dropped;
    logic       par_en, pbit;
    int         last_tick;
    d         = data & 8'((1 << nbits) - 1);
    par_en    = (par == PAR_EVEN) || (par == PAR_ODD);
    pbit      = (^d) ^ (par == PAR_ODD) ^ bad_par;
    last_tick = 1 + nbits + int'(par_en) + int'(stop2);
    cfg_data_bits = 2'(nbits - 5);
    cfg_parity    = par;
    cfg_stop2     = stop2;
    fork
      begin
        drive_bit(1'b0);
        if (scramble) begin
          cfg_data_bits = 2'($urandom);
          cfg_parity    = 2'($urandom);
          cfg_stop2     = 1'($urandom);
        end
        for (int i = 0; i < nbits; i++) drive_bit(d[i]);
        if (par_en) drive_bit(pbit);
        drive_bit(s1);
        if (stop2) drive_bit(s2);
        i_rxd = 1'b1;
        repeat (16) @(negedge clk);
      end
      begin
        if (pop_on_push) begin
          repeat (8 + period / 2 + last_tick * (period + 1)) @(negedge clk);
          check("pop_head", o_data, model_q[0][7:0]);
          rd_en = 1'b1;
          @(negedge clk);
          rd_en = 1'b0;
          check("count_push_pop", o_count, DEPTH);
        end
      end
    join
    if (pop_on_push) dropped = model_q.pop_front();
    model_push({~s1 | (stop2 & ~s2), par_en & bad_par, d});
  endtask

  task automatic check_state(input string tag);
    check({tag, "_count"},   o_count,   model_q.size());
    check({tag, "_valid"},   o_valid,   model_q.size() != 0);
    check({tag, "_overrun"}, o_overrun, model_ovr);
  endtask

  task automatic read_check(input string tag);
    logic [9:0] e;
    if (model_q.size() == 0) begin
      check({tag, "_valid"}, o_valid, 0);
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      check({tag, "_empty_pop"}, o_count, 0);
    end else begin
      e = model_q.pop_front();
      check({tag, "_valid"}, o_valid, 1);
      check({tag, "_data"},  o_data,  e[7:0]);
      check({tag, "_perr"},  o_perr,  e[8]);
      check({tag, "_ferr"},  o_ferr,  e[9]);
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_data"},    o_data,    0);
    check({tag, "_perr"},    o_perr,    0);
    check({tag, "_ferr"},    o_ferr,    0);
    check({tag, "_valid"},   o_valid,   0);
    check({tag, "_count"},   o_count,   0);
    check({tag, "_overrun"}, o_overrun, 0);
  endtask

  task automatic pulse_clr();
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    model_ovr = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not complete, failures so far %0d", n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_zero("rst_held");
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("rst_release");

    // 8N1 0xA5 at i_period 103, then pop to empty.
    set_period(103);
    send(8'hA5, 8, PAR_NONE, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check_state("a5");
    read_check("a5");
    check_state("a5_popped");

    // 7E1 with a wrong parity bit, then 5O2 clean.
    send(8'h35, 7, PAR_EVEN, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    read_check("7e1_badpar");
    send(8'h1F, 5, PAR_ODD, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    read_check("5o2");

    // Second stop bit low.
    send(8'h5A, 8, PAR_NONE, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    read_check("stop2_low");

    // Break: line low for three frame times yields one ferr entry.
    cfg_data_bits = 2'd3;
    cfg_parity    = PAR_NONE;
    cfg_stop2     = 1'b0;
    i_rxd = 1'b0;
    repeat (30 * (period + 1)) @(negedge clk);
    i_rxd = 1'b1;
    repeat (2 * (period + 1)) @(negedge clk);
    model_push(10'h200);
    check_state("break");
    read_check("break");

    // Short glitch is filtered; a 10-cycle pulse is a false start.
    i_rxd = 1'b0;
    repeat (3) @(negedge clk);
    i_rxd = 1'b1;
    repeat (3 * (period + 1)) @(negedge clk);
    check_state("glitch");
    i_rxd = 1'b0;
    repeat (10) @(negedge clk);
    i_rxd = 1'b1;
    repeat (3 * (period + 1)) @(negedge clk);
    check_state("false_start");

    // Overrun: five frames into a four-entry queue.
    for (int v = 1; v <= 5; v++)
      send(8'(v), 8, PAR_NONE, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check_state("overrun");
    for (int i = 0; i < 4; i++) read_check($sformatf("ovr_rd%0d", i));
    read_check("ovr_empty");
    check_state("ovr_drained");
    pulse_clr();
    check_state("ovr_cleared");

    // Full queue with a pop in the push cycle: no overrun, count stays full.
    set_period(15);
    for (int v = 0; v < 4; v++)
      send(8'h10 + 8'(v), 8, PAR_NONE, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    send(8'h14, 8, PAR_NONE, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    check_state("full_pop");
    for (int i = 0; i < 4; i++) read_check($sformatf("fp_rd%0d", i));

    // Reset in the middle of a data bit, with an entry already queued.
    set_period(103);
    send(8'h77, 8, PAR_NONE, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    i_rxd = 1'b0;
    repeat (period + 1) @(negedge clk);
    i_rxd = 1'b1;
    repeat (period / 2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_zero("mid_reset");
    model_q.delete();
    model_ovr = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check_state("post_reset");
    send(8'hC3, 8, PAR_NONE, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    read_check("post_reset_c3");

    // Randomized frames, configs, errors, reads and overrun clears.
    for (int n = 0; n < 40; n++) begin
      set_period($urandom_range(15, 40));
      send(8'($urandom), $urandom_range(5, 8), 2'($urandom), 1'($urandom),
           $urandom_range(0, 3) == 0, $urandom_range(0, 7) != 0,
           $urandom_range(0, 7) != 0, 1'b1, 1'b0);
      check_state($sformatf("rnd%0d", n));
      repeat ($urandom_range(0, 2)) read_check($sformatf("rnd%0d_rd", n));
      if (model_ovr && $urandom_range(0, 1) == 1) begin
        pulse_clr();
        check_state($sformatf("rnd%0d_clr", n));
      end
    end
    while (model_q.size() != 0) read_check("drain");
    check_state("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
